// File: rtl/hazard_scoreboard_pkg.sv
// Shared widths and types for the decode-stage hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int REG_ADDR_W         = 5;
    localparam int ACC_CNT_W          = 4;
    localparam int SB_MAX_ACC_PENDING = 4;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    typedef struct packed {
        logic load_use;
        logic raw_pend;
        logic waw_pend;
        logic acc_full;
    } hazard_t;

endpackage

// File: rtl/hazard_scoreboard_acc_counter.sv
// Outstanding accelerator-op counter: up/down, never underflows, flags full at MAX.
module hazard_scoreboard_acc_counter
    import hazard_scoreboard_pkg::*;
#(
    parameter int MAX = SB_MAX_ACC_PENDING
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 dec,
    output logic [ACC_CNT_W-1:0] cnt,
    output logic                 full
);

    logic inc_ok;
    logic dec_ok;

    // Decrement at zero is a spurious writeback; it is ignored here and flagged upstream.
    assign dec_ok = dec && (cnt != '0);
    assign inc_ok = inc && (cnt != '1);
    assign full   = (cnt == ACC_CNT_W'(MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc_ok && !dec_ok) begin
            cnt <= cnt + 1'b1;
        end else if (!inc_ok && dec_ok) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard tracker: stalls ID on load-use, pending accelerator RAW/WAW
// and accelerator queue full; consumes the accelerator writeback handshake.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS        = 32,
    parameter int MAX_ACC_PENDING = SB_MAX_ACC_PENDING
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic [REG_ADDR_W-1:0] rd_id,
    input  logic                  use_rs1_id,
    input  logic                  use_rs2_id,
    input  logic                  reg_write_id,
    input  logic                  is_load_id,
    input  logic                  is_acc_id,
    input  logic                  flush_ex,
    input  logic                  acc_wb_valid,
    input  logic [REG_ADDR_W-1:0] acc_wb_rd,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  bubble_ex,
    output logic [ACC_CNT_W-1:0]  acc_pending_cnt,
    output logic                  sb_err
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic                ex_load_valid;
    reg_idx_t            ex_load_rd;
    hazard_t             hz;
    logic                stall;
    logic                fire;
    logic                acc_full;
    logic                wb_err;

    always_comb begin
        hz.load_use = ex_load_valid && (ex_load_rd != '0) &&
                      ((use_rs1_id && (rs1_id == ex_load_rd)) ||
                       (use_rs2_id && (rs2_id == ex_load_rd)));
        hz.raw_pend = (use_rs1_id && pending[rs1_id]) || (use_rs2_id && pending[rs2_id]);
        hz.waw_pend = reg_write_id && (rd_id != '0) && pending[rd_id];
        hz.acc_full = is_acc_id && acc_full;
        stall       = id_valid && (|hz);
        fire        = id_valid && !stall && !flush_ex;
    end

    assign stall_if  = stall;
    assign stall_id  = stall;
    assign bubble_ex = stall;

    // Set is applied after clear so a forced same-register collision keeps the bit.
    always_comb begin
        set_vec     = '0;
        clr_vec     = '0;
        if (fire && is_acc_id && reg_write_id && (rd_id != '0)) begin
            set_vec = NUM_REGS'(1) << rd_id;
        end
        if (acc_wb_valid) begin
            clr_vec = NUM_REGS'(1) << acc_wb_rd;
        end
        pending_nxt = ((pending & ~clr_vec) | set_vec) & ~NUM_REGS'(1);
        wb_err      = acc_wb_valid && (acc_wb_rd != '0) && !pending[acc_wb_rd];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending       <= '0;
            ex_load_valid <= 1'b0;
            ex_load_rd    <= '0;
            sb_err        <= 1'b0;
        end else begin
            pending       <= pending_nxt;
            ex_load_valid <= fire && is_load_id && reg_write_id;
            ex_load_rd    <= rd_id;
            if (wb_err) begin
                sb_err <= 1'b1;
            end
        end
    end

    hazard_scoreboard_acc_counter #(
        .MAX (MAX_ACC_PENDING)
    ) u_acc_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (fire && is_acc_id),
        .dec   (acc_wb_valid),
        .cnt   (acc_pending_cnt),
        .full  (acc_full)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random traffic
// compared against a register-array reference model.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] rs1_id, rs2_id, rd_id;
    logic       use_rs1_id, use_rs2_id, reg_write_id, is_load_id, is_acc_id;
    logic       flush_ex;
    logic       acc_wb_valid;
    logic [4:0] acc_wb_rd;
    logic       stall_if, stall_id, bubble_ex;
    logic [3:0] acc_pending_cnt;
    logic       sb_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_pend [32];
    int m_cnt;
    bit m_ld_v;
    int m_ld_rd;
    bit m_err;

    localparam int MAXP = 4;

    hazard_scoreboard dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .rs1_id          (rs1_id),
        .rs2_id          (rs2_id),
        .rd_id           (rd_id),
        .use_rs1_id      (use_rs1_id),
        .use_rs2_id      (use_rs2_id),
        .reg_write_id    (reg_write_id),
        .is_load_id      (is_load_id),
        .is_acc_id       (is_acc_id),
        .flush_ex        (flush_ex),
        .acc_wb_valid    (acc_wb_valid),
        .acc_wb_rd       (acc_wb_rd),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .bubble_ex       (bubble_ex),
        .acc_pending_cnt (acc_pending_cnt),
        .sb_err          (sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_cnt   = 0;
        m_ld_v  = 1'b0;
        m_ld_rd = 0;
        m_err   = 1'b0;
    endtask

    function automatic bit exp_stall();
        bit lu, raw, waw, full;
        lu   = m_ld_v && m_ld_rd != 0 &&
               ((use_rs1_id && int'(rs1_id) == m_ld_rd) || (use_rs2_id && int'(rs2_id) == m_ld_rd));
        raw  = (use_rs1_id && m_pend[rs1_id]) || (use_rs2_id && m_pend[rs2_id]);
        waw  = reg_write_id && rd_id != 0 && m_pend[rd_id];
        full = is_acc_id && m_cnt == MAXP;
        return id_valid && (lu || raw || waw || full);
    endfunction

    task automatic model_clock(input bit s);
        bit fire;
        int old_cnt;
        fire    = id_valid && !s && !flush_ex;
        old_cnt = m_cnt;
        if (acc_wb_valid) begin
            if (acc_wb_rd != 0 && !m_pend[acc_wb_rd]) m_err = 1'b1;
            m_pend[acc_wb_rd] = 1'b0;
            if (old_cnt > 0) m_cnt = m_cnt - 1;
        end
        if (fire && is_acc_id) begin
            m_cnt = m_cnt + 1;
            if (reg_write_id && rd_id != 0) m_pend[rd_id] = 1'b1;
        end
        m_ld_v  = fire && is_load_id && reg_write_id;
        m_ld_rd = int'(rd_id);
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        bit s;
        #1;
        s = exp_stall();
        chk("stall_if", stall_if, s);
        chk("stall_id", stall_id, s);
        chk("bubble_ex", bubble_ex, s);
        chk("acc_cnt", acc_pending_cnt, m_cnt);
        chk("sb_err", sb_err, m_err);
        @(posedge clk);
        model_clock(s);
        @(negedge clk);
    endtask

    task automatic id_op(input bit v, input int r1, input int r2, input int rd,
                         input bit u1, input bit u2, input bit rw, input bit ld, input bit acc);
        id_valid     = v;
        rs1_id       = 5'(r1);
        rs2_id       = 5'(r2);
        rd_id        = 5'(rd);
        use_rs1_id   = u1;
        use_rs2_id   = u2;
        reg_write_id = rw;
        is_load_id   = ld;
        is_acc_id    = acc;
    endtask

    task automatic wb(input bit v, input int rd);
        acc_wb_valid = v;
        acc_wb_rd    = 5'(rd);
    endtask

    task automatic idle();
        id_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb(0, 0);
        flush_ex = 1'b0;
    endtask

    initial begin
        int cand [$];
        rst_n = 1'b0;
        idle();
        model_reset();
        #2;
        chk("rst_stall", stall_if, 0);
        chk("rst_cnt", acc_pending_cnt, 0);
        chk("rst_err", sb_err, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use: lw x5, then add x6,x5,x1 stalls exactly once
        id_op(1, 0, 0, 5, 0, 0, 1, 1, 0); step();
        id_op(1, 5, 1, 6, 1, 1, 1, 0, 0);
        #1 chk("lu_stall_first", stall_id, 1);
        step();
        #1 chk("lu_stall_second", stall_id, 0);
        step();
        // Load to x0 never creates a load-use hazard
        id_op(1, 0, 0, 0, 0, 0, 1, 1, 0); step();
        id_op(1, 0, 0, 7, 1, 0, 1, 0, 0);
        #1 chk("lu_x0", stall_id, 0);
        step();

        // Flush squashes the load: no load-use bubble for the consumer
        id_op(1, 0, 0, 5, 0, 0, 1, 1, 0); flush_ex = 1'b1; step();
        flush_ex = 1'b0;
        id_op(1, 5, 0, 6, 1, 0, 1, 0, 0);
        #1 chk("flush_no_lu", stall_id, 0);
        step();

        // Fill accelerator queue: x1..x4, then 5th op stalls even with writeback of x2
        for (int r = 1; r <= 4; r++) begin
            id_op(1, 0, 0, r, 0, 0, 1, 0, 1); step();
        end
        chk("full_cnt", acc_pending_cnt, 4);
        id_op(1, 0, 0, 8, 0, 0, 1, 0, 1); wb(1, 2);
        #1 chk("full_stall", stall_id, 1);
        step();
        wb(0, 0);
        #1 chk("full_fire", stall_id, 0);
        step();
        idle();
        #1 chk("full_cnt_after", acc_pending_cnt, 4);
        step();
        foreach (cand[i]) cand.delete(i);
        cand = '{1, 3, 4, 8};
        foreach (cand[i]) begin
            wb(1, cand[i]); step();
        end
        wb(0, 0);

        // WAW: load to x9 blocked while acc op to x9 pending; then spurious writeback
        id_op(1, 0, 0, 9, 0, 0, 1, 0, 1); step();
        id_op(1, 0, 0, 9, 0, 0, 1, 1, 0);
        #1 chk("waw_stall", stall_id, 1);
        step();
        id_op(1, 0, 0, 9, 0, 0, 1, 1, 0); wb(1, 9); step();
        idle(); step();
        wb(1, 10); step();
        wb(1, 10); step();
        idle();
        #1 chk("err_sticky", sb_err, 1);
        chk("no_underflow", acc_pending_cnt, 0);
        step();

        // Accel RAW: reader of x7 waits through the writeback cycle, proceeds after
        id_op(1, 0, 0, 7, 0, 0, 1, 0, 1); step();
        id_op(1, 7, 0, 11, 1, 0, 1, 0, 0); step(); step();
        wb(1, 7);
        #1 chk("raw_wb_cycle", stall_id, 1);
        step();
        wb(0, 0);
        #1 chk("raw_after_wb", stall_id, 0);
        step();

        // Mid-run reset with x5 pending and two ops outstanding
        idle();
        id_op(1, 0, 0, 5, 0, 0, 1, 0, 1); step();
        id_op(1, 0, 0, 6, 0, 0, 1, 0, 1); step();
        id_op(1, 5, 0, 12, 1, 0, 1, 0, 0);
        #1 chk("pre_rst_stall", stall_id, 1);
        chk("pre_rst_cnt", acc_pending_cnt, 2);
        #1 rst_n = 1'b0;
        #1 chk("async_rst_stall", stall_if, 0);
        chk("async_rst_bubble", bubble_ex, 0);
        chk("async_rst_cnt", acc_pending_cnt, 0);
        chk("async_rst_err", sb_err, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Random traffic on a small register window to provoke collisions
        for (int n = 0; n < 600; n++) begin
            int kind;
            kind = $urandom_range(0, 3);
            id_op($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 3) != 0, kind == 1, kind == 2);
            flush_ex = ($urandom_range(0, 7) == 0);
            cand.delete();
            for (int r = 1; r < 32; r++) if (m_pend[r]) cand.push_back(r);
            if ($urandom_range(0, 15) == 0) begin
                wb(1, $urandom_range(0, 7));
            end else if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
                wb(1, cand[$urandom_range(0, cand.size() - 1)]);
            end else begin
                wb(0, 0);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
